// File: rtl/interp_step_ramp_ctrl.sv
// Step-rate ramp controller: slews the interpolator step toward a handshaken target by a
// programmable rate per input-sample strobe. Optional mid-ramp retargeting: INTERP_RETARGET_EN.
module interp_step_ramp_ctrl #(
  parameter int                   CTRBITS   = 32,
  parameter int                   RATEW     = 16,
  parameter logic [CTRBITS-1:0]   INIT_STEP = {CTRBITS{1'b0}}
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [CTRBITS-1:0] i_cfg_step,
  input  logic [RATEW-1:0]   i_cfg_rate,
  input  logic               i_ce,
  input  logic               i_abort,
  output logic [CTRBITS-1:0] o_step,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RAMP = 1'b1;

  logic [0:0]         state_r,  state_nx_s;
  logic [CTRBITS-1:0] step_r,   step_nx_s;
  logic [CTRBITS-1:0] target_r, target_nx_s;
  logic [RATEW-1:0]   rate_r,   rate_nx_s;
  logic               done_r,   done_nx_s;
  logic               ready_r,  ready_nx_s;
  logic               cfg_ready_s;
  logic               xfer_s;
  logic [CTRBITS:0]   diff_s;
  logic [CTRBITS:0]   mag_s;
  logic [CTRBITS:0]   rate_ext_s;
  logic               within_s;
  logic [CTRBITS-1:0] step_up_s;
  logic [CTRBITS-1:0] step_dn_s;

  // Signed distance to target; the clamp to target guarantees the +/- rate paths never wrap.
  assign diff_s     = {1'b0, target_r} - {1'b0, step_r};
  assign mag_s      = diff_s[CTRBITS] ? ({(CTRBITS+1){1'b0}} - diff_s) : diff_s;
  assign rate_ext_s = {{(CTRBITS+1-RATEW){1'b0}}, rate_r};
  assign within_s   = (mag_s <= rate_ext_s);
  assign step_up_s  = step_r + rate_ext_s[CTRBITS-1:0];
  assign step_dn_s  = step_r - rate_ext_s[CTRBITS-1:0];

`ifdef INTERP_RETARGET_EN
  assign cfg_ready_s = ready_r & ~(i_abort & (state_r == ST_RAMP));
`else
  assign cfg_ready_s = ready_r;
`endif
  assign xfer_s = i_cfg_valid & cfg_ready_s;

  // Next-state, step, target and done computation.
  always_comb begin
    state_nx_s  = state_r;
    step_nx_s   = step_r;
    target_nx_s = target_r;
    rate_nx_s   = rate_r;
    done_nx_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          target_nx_s = i_cfg_step;
          rate_nx_s   = i_cfg_rate;
          if (i_cfg_rate == {RATEW{1'b0}}) begin
            step_nx_s = i_cfg_step;
            done_nx_s = 1'b1;
          end else begin
            state_nx_s = ST_RAMP;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RAMP: begin
        if (i_abort) begin
          state_nx_s = ST_IDLE;
        end else begin
          if (i_ce) begin
            if (within_s) begin
              step_nx_s  = target_r;
              done_nx_s  = 1'b1;
              state_nx_s = ST_IDLE;
            end else if (diff_s[CTRBITS]) begin
              step_nx_s = step_dn_s;
            end else begin
              step_nx_s = step_up_s;
            end
          end else begin
            step_nx_s = step_r;
          end
`ifdef INTERP_RETARGET_EN
          // A retarget overrides completion; a coincident strobe still used the old target/rate.
          if (xfer_s) begin
            target_nx_s = i_cfg_step;
            rate_nx_s   = i_cfg_rate;
            if (i_cfg_rate == {RATEW{1'b0}}) begin
              step_nx_s  = i_cfg_step;
              done_nx_s  = 1'b1;
              state_nx_s = ST_IDLE;
            end else begin
              done_nx_s  = 1'b0;
              state_nx_s = ST_RAMP;
            end
          end else begin
            target_nx_s = target_r;
          end
`endif
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

`ifdef INTERP_RETARGET_EN
  assign ready_nx_s = 1'b1;
`else
  // Ready returns only after a full idle cycle, so it trails the done pulse by one clock.
  assign ready_nx_s = (state_nx_s == ST_IDLE) && (state_r == ST_IDLE);
`endif

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r  <= ST_IDLE;
      step_r   <= INIT_STEP;
      target_r <= INIT_STEP;
      rate_r   <= {RATEW{1'b0}};
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      state_r  <= state_nx_s;
      step_r   <= step_nx_s;
      target_r <= target_nx_s;
      rate_r   <= rate_nx_s;
      done_r   <= done_nx_s;
      ready_r  <= ready_nx_s;
    end
  end

  assign o_step      = step_r;
  assign o_busy      = (state_r == ST_RAMP);
  assign o_done      = done_r;
  assign o_cfg_ready = cfg_ready_s;

endmodule

// File: tb/tb_interp_step_ramp_ctrl.sv
// Directed testbench for interp_step_ramp_ctrl with hand-computed expectations.
module tb_interp_step_ramp_ctrl;

  localparam logic [31:0] INIT = 32'h1000_0000;

  logic        clk;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_step;
  logic [15:0] cfg_rate;
  logic        ce;
  logic        abort_s;
  logic [31:0] step;
  logic        busy;
  logic        done;

  int passed;
  int total;

  interp_step_ramp_ctrl #(
    .CTRBITS  (32),
    .RATEW    (16),
    .INIT_STEP(INIT)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_cfg_valid(cfg_valid),
    .o_cfg_ready(cfg_ready),
    .i_cfg_step (cfg_step),
    .i_cfg_rate (cfg_rate),
    .i_ce       (ce),
    .i_abort    (abort_s),
    .o_step     (step),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Two idle clocks, then one strobe edge; outputs are sampled just after the strobe edge.
  task automatic ce_pulse();
    tick();
    tick();
    ce = 1'b1;
    tick();
    ce = 1'b0;
  endtask

  task automatic offer(input logic [31:0] s, input logic [15:0] r);
    cfg_valid = 1'b1;
    cfg_step  = s;
    cfg_rate  = r;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    passed = 0;
    total = 0;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    cfg_step = 32'h0;
    cfg_rate = 16'h0;
    ce = 1'b0;
    abort_s = 1'b0;

    // Reset state
    #12;
    chk("rst_step", step, INIT);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'b0, cfg_ready}, 32'h1);
    chk("rst_step2", step, INIT);

    // Up ramp
    offer(32'h1000_0100, 16'h0040);
    chk("up_busy", {31'b0, busy}, 32'h1);
    chk("up_ready0", {31'b0, cfg_ready}, 32'h0);
    chk("up_step0", step, INIT);
    for (int k = 1; k <= 3; k++) begin
      ce_pulse();
      chk("up_step", step, INIT + 32'h40 * k);
      chk("up_nodone", {31'b0, done}, 32'h0);
      chk("up_ready", {31'b0, cfg_ready}, 32'h0);
    end
    ce_pulse();
    chk("up_final", step, 32'h1000_0100);
    chk("up_done", {31'b0, done}, 32'h1);
    chk("up_busy_end", {31'b0, busy}, 32'h0);
    chk("up_ready_lag", {31'b0, cfg_ready}, 32'h0);
    tick();
    chk("up_done_clr", {31'b0, done}, 32'h0);
    chk("up_ready_back", {31'b0, cfg_ready}, 32'h1);

    // Down ramp with clamp (rate-0 jump to the start point first)
    offer(32'h0000_0100, 16'h0000);
    chk("dn_jump", step, 32'h0000_0100);
    chk("dn_jump_done", {31'b0, done}, 32'h1);
    offer(32'h0000_0010, 16'h0050);
    chk("dn_busy", {31'b0, busy}, 32'h1);
    ce_pulse();
    chk("dn_s1", step, 32'h0000_00B0);
    chk("dn_d1", {31'b0, done}, 32'h0);
    ce_pulse();
    chk("dn_s2", step, 32'h0000_0060);
    ce_pulse();
    chk("dn_s3", step, 32'h0000_0010);
    chk("dn_d3", {31'b0, done}, 32'h1);
    tick();
    ce = 1'b1;
    tick();
    ce = 1'b0;
    chk("dn_hold", step, 32'h0000_0010);
    chk("dn_d_clr", {31'b0, done}, 32'h0);

    // Rate-0 jump
    offer(32'hDEAD_BEEF, 16'h0000);
    chk("jmp_step", step, 32'hDEAD_BEEF);
    chk("jmp_done", {31'b0, done}, 32'h1);
    chk("jmp_busy", {31'b0, busy}, 32'h0);
    tick();
    chk("jmp_done_clr", {31'b0, done}, 32'h0);
    chk("jmp_busy2", {31'b0, busy}, 32'h0);

    // Abort on the 5th strobe
    offer(32'h0000_0000, 16'h0000);
    chk("ab_zero", step, 32'h0);
    offer(32'h0000_1000, 16'h0100);
    for (int k = 1; k <= 4; k++) begin
      ce_pulse();
      chk("ab_step", step, 32'h100 * k);
    end
    tick();
    tick();
    ce = 1'b1;
    abort_s = 1'b1;
    tick();
    ce = 1'b0;
    abort_s = 1'b0;
    chk("ab_held", step, 32'h0000_0400);
    chk("ab_busy", {31'b0, busy}, 32'h0);
    chk("ab_nodone", {31'b0, done}, 32'h0);
    ce = 1'b1;
    tick();
    ce = 1'b0;
    chk("ab_idle_ce", step, 32'h0000_0400);
    chk("ab_idle_abort", {31'b0, done}, 32'h0);

`ifndef INTERP_RETARGET_EN
    // Request held during a ramp is only taken after the abort
    offer(32'h0000_5555, 16'h0010);
    chk("hv_busy", {31'b0, busy}, 32'h1);
    cfg_valid = 1'b1;
    cfg_step  = 32'h0000_0777;
    cfg_rate  = 16'h0000;
    tick();
    tick();
    chk("hv_wait_ready", {31'b0, cfg_ready}, 32'h0);
    chk("hv_wait_step", step, 32'h0000_0400);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk("hv_abort_busy", {31'b0, busy}, 32'h0);
    chk("hv_abort_step", step, 32'h0000_0400);
    tick();
    chk("hv_ready", {31'b0, cfg_ready}, 32'h1);
    chk("hv_not_yet", step, 32'h0000_0400);
    tick();
    cfg_valid = 1'b0;
    chk("hv_taken", step, 32'h0000_0777);
    chk("hv_done", {31'b0, done}, 32'h1);
    offer(32'h0000_0400, 16'h0000);
    chk("hv_restore", step, 32'h0000_0400);
    tick();
`endif

    // Retarget from 0x300
    offer(32'h0000_0000, 16'h0100);
    ce_pulse();
    chk("rt_start", step, 32'h0000_0300);
`ifdef INTERP_RETARGET_EN
    chk("rt_ready", {31'b0, cfg_ready}, 32'h1);
    offer(32'h0000_0200, 16'h0080);
    chk("rt_busy", {31'b0, busy}, 32'h1);
    chk("rt_step0", step, 32'h0000_0300);
    ce_pulse();
    chk("rt_s1", step, 32'h0000_0280);
    chk("rt_d1", {31'b0, done}, 32'h0);
    ce_pulse();
    chk("rt_s2", step, 32'h0000_0200);
    chk("rt_d2", {31'b0, done}, 32'h1);
    tick();
    chk("rt_d_clr", {31'b0, done}, 32'h0);
`else
    cfg_valid = 1'b1;
    cfg_step  = 32'h0000_0200;
    cfg_rate  = 16'h0080;
    tick();
    chk("rt_ready", {31'b0, cfg_ready}, 32'h0);
    chk("rt_busy", {31'b0, busy}, 32'h1);
    ce_pulse();
    chk("rt_oldtgt", step, 32'h0000_0200);
    chk("rt_nodone", {31'b0, done}, 32'h0);
    abort_s = 1'b1;
    tick();
    abort_s = 1'b0;
    chk("rt_abort", {31'b0, busy}, 32'h0);
    tick();
    tick();
    cfg_valid = 1'b0;
    chk("rt_eq_busy", {31'b0, busy}, 32'h1);
    ce_pulse();
    chk("rt_eq_step", step, 32'h0000_0200);
    chk("rt_eq_done", {31'b0, done}, 32'h1);
    chk("rt_eq_idle", {31'b0, busy}, 32'h0);
    tick();
`endif

    // Asynchronous reset mid-ramp
    offer(32'h0000_0900, 16'h0100);
    ce_pulse();
    chk("mr_step", step, 32'h0000_0300);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mr_async_step", step, INIT);
    chk("mr_async_busy", {31'b0, busy}, 32'h0);
    chk("mr_async_done", {31'b0, done}, 32'h0);
    chk("mr_async_ready", {31'b0, cfg_ready}, 32'h1);
    #2;
    rst_n = 1'b1;
    ce = 1'b1;
    tick();
    ce = 1'b0;
    chk("mr_after_step", step, INIT);
    chk("mr_after_done", {31'b0, done}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
